// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative multiply/divide engine (MULT/MULTU/DIV/DIVU).
// Result commits WIDTH+2 edges after the start edge; start is ignored while busy, cancel aborts.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dz_q, dz_d;

  logic                 accept, commit, is_div, is_signed, dz_op;
  logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   prod;

  assign accept    = (state_q == S_IDLE) && start && !cancel;
  assign commit    = (state_q == S_FIX) && !cancel;
  assign is_div    = op_q[1];
  assign is_signed = !op_q[0];
  assign dz_op     = is_div && (b_q == '0);

  assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};

  // Divide: shift the next dividend bit into the partial remainder and try a subtract.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, b_q};

  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_PREP;
      S_PREP:  state_d = cancel ? S_IDLE : S_CALC;
      S_CALC: begin
        if (cancel)                         state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))        state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next-state
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = commit;
    dz_d   = commit && dz_op;

    if (accept) begin
      op_d = op;
      a_d  = a;
      b_d  = b;
    end

    case (state_q)
      S_PREP: begin
        sa_d  = is_signed && a_q[WIDTH-1];
        sb_d  = is_signed && b_q[WIDTH-1];
        acc_d = {{WIDTH{1'b0}}, mag_a};
        b_d   = mag_b;
        cnt_d = CNT_W'(WIDTH);
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!is_div)
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      default: ;
    endcase

    if (wr_hi) hi_d = wdata;
    if (wr_lo) lo_d = wdata;

    // The engine result takes priority over a direct write landing on the same edge.
    if (commit) begin
      if (!is_div) begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end else if (dz_op) begin
        hi_d = a_q;
        lo_d = {WIDTH{1'b1}};
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
